tx_fifo_arbiter: RTL and testbench

- Controller for the transmit-path FIFOs. Drains four virtual-channel source FIFOs round-robin into one shared destination (main) FIFO.
- Manages destination backpressure with hysteresis using the FIFO threshold flags.
- Latches the threshold (Umbral) configuration and drives it to all FIFOs.
- Stops all traffic on any FIFO error flag.

---
 rtl/tx_pkg.sv | 20 ++
 rtl/tx_fifo_arbiter_rr.sv | 35 +++
 rtl/tx_fifo_arbiter.sv | 131 +++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit-path FIFO arbiter.
// Holds the FSM state encoding, the fixed source count and the
// default threshold values used when configuring the FIFOs.
package tx_pkg;

   localparam int NUM_SRC = 4;

   localparam logic [3:0] UMBRAL_MAIN_DEF = 4'd1;
   localparam logic [3:0] UMBRAL_VC_DEF   = 4'd1;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_HOLD   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

endpackage

// File: rtl/tx_fifo_arbiter_rr.sv
// Combinational 4-way round-robin arbiter.
// Ports:
//   request   - one bit per source that has data
//   pointer   - index searched first; the search wraps 3 -> 0
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - index of the granted source (0 when no request)
// The pointer register lives in the parent.
module rr_arbiter4
   import tx_pkg::*;
(
   input  logic [3:0] request,
   input  logic [1:0] pointer,
   output logic [3:0] grant,
   output logic [1:0] grant_idx
);

   always_comb begin
      logic [1:0] idx;
      logic       found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         // 2-bit addition wraps naturally modulo 4
         idx = pointer + 2'(k);
         if (!found && request[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Transmit-path FIFO controller.
// Drains four virtual-channel source FIFOs round-robin into a single
// destination FIFO, applies hysteresis backpressure from the destination
// threshold flags, latches the threshold configuration and stops all
// traffic on any FIFO error.
// Ports:
//   clk, reset (async, active-low)
//   init                          - config mode, thresholds load while high
//   umbral_main_in, umbral_vc_in  - threshold values to latch
//   src_empty, src_error          - per-source flags
//   src_data                      - source i at bits [i*data_width +: data_width]
//   dst_full .. dst_error         - destination FIFO flags
//   src_pop                       - one-hot read enable to the sources
//   dst_push, dst_data            - write enable / data to the destination
//   umbral_main, umbral_vc        - latched thresholds
//   state, idle, error_out        - status
module tx_fifo_arbiter #(
   parameter int data_width = 6,
   parameter int NUM_SRC    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          init,
   input  logic [3:0]                    umbral_main_in,
   input  logic [3:0]                    umbral_vc_in,
   input  logic [NUM_SRC-1:0]            src_empty,
   input  logic [NUM_SRC-1:0]            src_error,
   input  logic [NUM_SRC*data_width-1:0] src_data,
   input  logic                          dst_full,
   input  logic                          dst_almost_full,
   input  logic                          dst_almost_empty,
   input  logic                          dst_empty,
   input  logic                          dst_error,
   output logic [NUM_SRC-1:0]            src_pop,
   output logic                          dst_push,
   output logic [data_width-1:0]         dst_data,
   output logic [3:0]                    umbral_main,
   output logic [3:0]                    umbral_vc,
   output logic [2:0]                    state,
   output logic                          idle,
   output logic                          error_out
);

   import tx_pkg::*;

   state_t               st_q;
   logic [1:0]           rr_ptr;
   logic [1:0]           grant_q;
   logic                 pop_q;
   logic [NUM_SRC-1:0]   request;
   logic [NUM_SRC-1:0]   grant;
   logic [1:0]           grant_idx;
   logic                 any_err;
   logic                 hold_cond;
   logic                 release_cond;
   logic                 pop_en;

   assign request      = ~src_empty;
   assign any_err      = (|src_error) | dst_error;
   assign hold_cond    = dst_almost_full | dst_full;
   assign release_cond = dst_almost_empty | dst_empty;

   rr_arbiter4 u_rr (
      .request   (request),
      .pointer   (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Pops stop in the very cycle the destination reports it is filling up,
   // so at most the one word popped in the previous cycle is still in flight.
   assign pop_en  = (st_q == ST_ACTIVE) && !hold_cond;
   assign src_pop = pop_en ? grant : '0;

   // Sources register data_out, so the popped word is visible one cycle
   // after the pop; the push is driven from the registered pop/grant.
   assign dst_push  = pop_q;
   assign dst_data  = pop_q ? src_data[grant_q*data_width +: data_width] : '0;

   assign state     = st_q;
   assign idle      = (st_q == ST_IDLE) && !pop_q;
   assign error_out = (st_q == ST_ERROR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= ST_RESET;
         rr_ptr      <= '0;
         grant_q     <= '0;
         pop_q       <= 1'b0;
         umbral_main <= '0;
         umbral_vc   <= '0;
      end else begin
         pop_q <= |src_pop;
         if (|src_pop) begin
            grant_q <= grant_idx;
            rr_ptr  <= grant_idx + 2'd1;
         end

         if (st_q == ST_INIT) begin
            umbral_main <= umbral_main_in;
            umbral_vc   <= umbral_vc_in;
         end

         if (any_err && (st_q != ST_RESET)) begin
            st_q <= ST_ERROR;
         end else begin
            case (st_q)
               ST_RESET:  st_q <= init ? ST_INIT : ST_IDLE;
               ST_INIT:   st_q <= init ? ST_INIT : ST_IDLE;
               ST_IDLE: begin
                  if (init)          st_q <= ST_INIT;
                  else if (|request) st_q <= ST_ACTIVE;
               end
               ST_ACTIVE: begin
                  // HOLD entry outranks going idle
                  if (hold_cond)                  st_q <= ST_HOLD;
                  else if (!(|request) && !pop_q) st_q <= ST_IDLE;
               end
               ST_HOLD: begin
                  // almost flags are equality compares, so leave HOLD only
                  // once the destination has drained to the low mark
                  if (release_cond) st_q <= ST_ACTIVE;
               end
               ST_ERROR:  st_q <= ST_ERROR;
               default:   st_q <= ST_RESET;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Self-checking bench for tx_fifo_arbiter. Source FIFOs are modelled as
// queues with a registered data_out; a cycle-level reference model predicts
// every output from the queue contents and the driven flags.
module tb_tx_fifo_arbiter;

   localparam int W = 6;

   logic           clk = 1'b0;
   logic           reset;
   logic           init;
   logic [3:0]     umbral_main_in, umbral_vc_in;
   logic [3:0]     src_empty, src_error;
   logic [4*W-1:0] src_data;
   logic           dst_full, dst_almost_full, dst_almost_empty, dst_empty, dst_error;
   logic [3:0]     src_pop;
   logic           dst_push;
   logic [W-1:0]   dst_data;
   logic [3:0]     umbral_main, umbral_vc;
   logic [2:0]     state;
   logic           idle, error_out;

   always #5 clk = ~clk;

   tx_fifo_arbiter #(.data_width(W), .NUM_SRC(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .init             (init),
      .umbral_main_in   (umbral_main_in),
      .umbral_vc_in     (umbral_vc_in),
      .src_empty        (src_empty),
      .src_error        (src_error),
      .src_data         (src_data),
      .dst_full         (dst_full),
      .dst_almost_full  (dst_almost_full),
      .dst_almost_empty (dst_almost_empty),
      .dst_empty        (dst_empty),
      .dst_error        (dst_error),
      .src_pop          (src_pop),
      .dst_push         (dst_push),
      .dst_data         (dst_data),
      .umbral_main      (umbral_main),
      .umbral_vc        (umbral_vc),
      .state            (state),
      .idle             (idle),
      .error_out        (error_out)
   );

   // source FIFO contents and their registered data_out
   logic [W-1:0] q[4][$];
   logic [W-1:0] dout[4];

   // reference model: state codes RESET=0 INIT=1 IDLE=2 ACTIVE=3 HOLD=4 ERROR=5
   int           m_state;
   int           m_rr;
   bit           m_popq;
   logic [W-1:0] m_word;
   logic [3:0]   m_um, m_uv;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int total_words();
      int t = 0;
      for (int i = 0; i < 4; i++) t += q[i].size();
      return t;
   endfunction

   task automatic model_clear();
      m_state = 0; m_rr = 0; m_popq = 0; m_word = '0; m_um = '0; m_uv = '0;
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         dout[i] = '0;
      end
   endtask

   // Called at a falling edge: drive the source view, check outputs,
   // advance the model across the next rising edge, return at next falling edge.
   task automatic run_cycle();
      int         g;
      int         ns;
      int         tot;
      logic [3:0] exp_pop;
      bit         hold_c, rel_c, err;
      for (int i = 0; i < 4; i++) begin
         src_empty[i]       = (q[i].size() == 0);
         src_data[i*W +: W] = dout[i];
      end
      #1;
      tot    = total_words();
      hold_c = dst_almost_full || dst_full;
      rel_c  = dst_almost_empty || dst_empty;
      err    = (src_error != 0) || dst_error;
      g = -1;
      if (m_state == 3 && !hold_c)
         for (int k = 0; k < 4; k++)
            if (g < 0 && q[(m_rr + k) % 4].size() != 0) g = (m_rr + k) % 4;
      exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;

      check_val("src_pop",     32'(src_pop),     32'(exp_pop));
      check_val("dst_push",    32'(dst_push),    32'(m_popq));
      check_val("dst_data",    32'(dst_data),    m_popq ? 32'(m_word) : 32'd0);
      check_val("state",       32'(state),       32'(m_state));
      check_val("idle",        32'(idle),        32'(m_state == 2 && !m_popq));
      check_val("error_out",   32'(error_out),   32'(m_state == 5));
      check_val("umbral_main", 32'(umbral_main), 32'(m_um));
      check_val("umbral_vc",   32'(umbral_vc),   32'(m_uv));

      case (m_state)
         0, 1:    ns = init ? 1 : 2;
         2:       ns = init ? 1 : (tot != 0 ? 3 : 2);
         3:       ns = hold_c ? 4 : ((tot == 0 && !m_popq) ? 2 : 3);
         4:       ns = rel_c ? 3 : 4;
         default: ns = 5;
      endcase
      if (m_state != 0 && err) ns = 5;
      if (m_state == 1) begin
         m_um = umbral_main_in;
         m_uv = umbral_vc_in;
      end
      m_popq = (g >= 0);
      if (g >= 0) begin
         m_word  = q[g].pop_front();
         dout[g] = m_word;
         m_rr    = (g + 1) % 4;
      end
      m_state = ns;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_val("rst_state",    32'(state),    32'd0);
      check_val("rst_src_pop",  32'(src_pop),  32'd0);
      check_val("rst_dst_push", 32'(dst_push), 32'd0);
      check_val("rst_dst_data", 32'(dst_data), 32'd0);
      check_val("rst_umbral",   32'({umbral_main, umbral_vc}), 32'd0);
      check_val("rst_status",   32'({idle, error_out}), 32'd0);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; init = 1'b0;
      umbral_main_in = '0; umbral_vc_in = '0;
      src_empty = '1; src_error = '0; src_data = '0;
      dst_full = 0; dst_almost_full = 0; dst_almost_empty = 0; dst_empty = 0; dst_error = 0;
      model_clear();
      do_reset();

      // configuration
      init = 1; umbral_main_in = 4'd1; umbral_vc_in = 4'd2;
      repeat (3) run_cycle();
      init = 0;
      repeat (2) run_cycle();
      check_val("cfg_main", 32'(umbral_main), 32'd1);
      check_val("cfg_vc",   32'(umbral_vc),   32'd2);

      // single source
      q[2].push_back(6'h11); q[2].push_back(6'h22);
      repeat (6) run_cycle();
      check_val("single_idle", 32'(idle), 32'd1);

      // round-robin from pointer 0
      do_reset();
      for (int i = 0; i < 4; i++) q[i].push_back(6'(i + 1));
      repeat (8) run_cycle();

      // backpressure with hysteresis
      do_reset();
      for (int i = 0; i < 6; i++) q[0].push_back(6'($urandom));
      for (int i = 0; i < 4; i++) q[3].push_back(6'($urandom));
      for (int n = 0; n < 20 && !(m_state == 3 && m_popq); n++) run_cycle();
      check_val("bp_stream_started", 32'(m_state == 3 && m_popq), 32'd1);
      dst_almost_full = 1;
      repeat (4) run_cycle();
      dst_almost_full = 0;
      repeat (2) run_cycle();
      dst_almost_empty = 1;
      run_cycle();
      dst_almost_empty = 0;
      for (int n = 0; n < 40 && !(total_words() == 0 && m_state == 2); n++) run_cycle();
      check_val("bp_drained", 32'(total_words() == 0 && m_state == 2), 32'd1);

      // randomized traffic with random destination flags and reconfiguration
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 3) == 0 && q[i].size() < 6) q[i].push_back(6'($urandom));
         dst_almost_full  = ($urandom_range(0, 7) == 0);
         dst_full         = ($urandom_range(0, 15) == 0);
         dst_almost_empty = ($urandom_range(0, 5) == 0);
         dst_empty        = ($urandom_range(0, 9) == 0);
         init             = ($urandom_range(0, 39) == 0);
         umbral_main_in   = 4'($urandom);
         umbral_vc_in     = 4'($urandom);
         run_cycle();
      end
      dst_almost_full = 0; dst_full = 0; dst_almost_empty = 0; dst_empty = 0; init = 0;

      // error: sticky, in-flight push completes, no further pops
      do_reset();
      for (int i = 0; i < 3; i++) begin
         q[0].push_back(6'($urandom));
         q[1].push_back(6'($urandom));
      end
      for (int n = 0; n < 20 && !(m_state == 3 && m_popq); n++) run_cycle();
      check_val("err_stream_started", 32'(m_state == 3 && m_popq), 32'd1);
      src_error = 4'b0010;
      run_cycle();
      src_error = 4'b0000;
      repeat (10) run_cycle();
      check_val("err_sticky", 32'(error_out), 32'd1);

      // asynchronous reset while a push is pending
      do_reset();
      for (int i = 0; i < 4; i++) q[1].push_back(6'($urandom));
      for (int n = 0; n < 20 && !m_popq; n++) run_cycle();
      check_val("ar_popq_set", 32'(m_popq), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_val("ar_push",  32'(dst_push), 32'd0);
      check_val("ar_data",  32'(dst_data), 32'd0);
      check_val("ar_pop",   32'(src_pop),  32'd0);
      check_val("ar_state", 32'(state),    32'd0);
      @(posedge clk);
      #1;
      check_val("ar_push_edge",  32'(dst_push), 32'd0);
      check_val("ar_state_edge", 32'(state),    32'd0);
      @(negedge clk);
      model_clear();
      reset = 1'b1;
      repeat (3) run_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
